// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: NOP encoding, major opcodes and fetch-stage state type.
// Used by if_fetch_stage (optional misalignment trap selected with IF_MISALIGN_CHECK_EN).
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/grant/response plus the decode valid/ready, redirect and flush.
// master = fetch stage side, slave = memory/decode environment side.
interface if_fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;

    logic            branch;
    logic            zero;
    logic [XLEN-1:0] branch_target;
    logic            flush;
    logic [XLEN-1:0] flush_pc;
    logic            fetch_fault;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_fault,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               branch, zero, branch_target, flush, flush_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_fault,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
               branch, zero, branch_target, flush, flush_pc
    );
endinterface

// File: rtl/if_fetch_stage_pc_next_sel.sv
// Next-PC mux: flush > taken branch > pc+4; combinational, no backpressure.
// IF_MISALIGN_CHECK_EN: flag misaligned targets; otherwise the low two bits are forced to zero.
module pc_next_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] raw_pc;

    always_comb begin
        raw_pc = pc + XLEN'(4);
        if (flush) begin
            raw_pc = flush_pc;
        end else if (taken) begin
            raw_pc = branch_target;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    assign next_pc    = raw_pc;
    assign misaligned = |raw_pc[1:0];
`else
    assign next_pc    = raw_pc & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: one outstanding imem request, result held to decode under valid/ready; 3-cycle peak loop.
// Decode backpressure holds instr/instr_pc in VALID; flush overrides everything (IF_MISALIGN_CHECK_EN adds FAULT).
module if_fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    if_fetch_stage_if.master   bus
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            instr_valid_q;
    logic            fetch_fault_q;
    logic            drop;
    logic            drop_fault;
    logic            run;

    logic            imem_req;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    // run keeps the request low until the first clock after reset release
    assign imem_req         = run & (state == ST_FETCH);
    assign bus.imem_req     = imem_req;
    assign bus.imem_addr    = pc;
    assign bus.instr        = instr_q;
    assign bus.instr_pc     = instr_pc_q;
    assign bus.instr_valid  = instr_valid_q;
    assign bus.fetch_fault  = fetch_fault_q;

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc            (pc),
        .flush         (bus.flush),
        .flush_pc      (bus.flush_pc),
        .taken         (bus.branch & bus.zero),
        .branch_target (bus.branch_target),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_FETCH;
            pc            <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            drop          <= 1'b0;
            drop_fault    <= 1'b0;
            run           <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_FETCH: begin
                    if (bus.flush) begin
                        pc <= next_pc;
                        if (imem_req && bus.imem_gnt) begin
                            // already granted: the response must still be swallowed
                            drop       <= 1'b1;
                            drop_fault <= misaligned;
                            state      <= ST_WAIT;
                        end else begin
                            fetch_fault_q <= misaligned;
                            state         <= misaligned ? ST_FAULT : ST_FETCH;
                        end
                    end else if (imem_req && bus.imem_gnt) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.flush) begin
                        pc <= next_pc;
                        if (bus.imem_rvalid) begin
                            drop          <= 1'b0;
                            fetch_fault_q <= misaligned;
                            state         <= misaligned ? ST_FAULT : ST_FETCH;
                        end else begin
                            drop       <= 1'b1;
                            drop_fault <= misaligned;
                        end
                    end else if (bus.imem_rvalid) begin
                        if (drop) begin
                            drop          <= 1'b0;
                            fetch_fault_q <= drop_fault;
                            state         <= drop_fault ? ST_FAULT : ST_FETCH;
                        end else begin
                            instr_q       <= bus.imem_rdata;
                            instr_pc_q    <= pc;
                            instr_valid_q <= 1'b1;
                            state         <= ST_VALID;
                        end
                    end
                end
                ST_VALID: begin
                    // next_pc already prefers flush_pc over the branch redirect
                    if (bus.flush || bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        pc            <= next_pc;
                        fetch_fault_q <= misaligned;
                        state         <= misaligned ? ST_FAULT : ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    if (bus.flush) begin
                        pc <= next_pc;
                        if (!misaligned) begin
                            fetch_fault_q <= 1'b0;
                            state         <= ST_FETCH;
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed fetch scenarios with an instruction scoreboard.
// Build with +define+IF_MISALIGN_CHECK_EN to exercise the fault path.
module tb_if_fetch_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   req_cyc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];

    if_fetch_stage_if #(.XLEN(32)) bus ();

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        check("req_timeout", 64'(bus.imem_req), 64'd1);
    endtask

    // One complete fetch: request/grant/response, optional stalls, then consume with a redirect
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                             input int gwait, input int rwait,
                             input logic br, input logic z, input logic [31:0] tgt);
        exp_t e;
        wait_req();
        check("req_addr", 64'(bus.imem_addr), 64'(addr));
        for (int i = 0; i < gwait; i++) begin
            tick();
            check("req_hold", 64'(bus.imem_req), 64'd1);
            check("addr_hold", 64'(bus.imem_addr), 64'(addr));
        end
        req_cyc = cyc;
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        sb.push_back('{pc: addr, ins: data});
        check("req_after_gnt", 64'(bus.imem_req), 64'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        check("valid_set", 64'(bus.instr_valid), 64'd1);
        for (int i = 0; i < rwait; i++) begin
            tick();
            check("stall_valid", 64'(bus.instr_valid), 64'd1);
            check("stall_instr", 64'(bus.instr), 64'(data));
            check("stall_pc", 64'(bus.instr_pc), 64'(addr));
            check("stall_noreq", 64'(bus.imem_req), 64'd0);
        end
        bus.instr_ready   = 1'b1;
        bus.branch        = br;
        bus.zero          = z;
        bus.branch_target = tgt;
        if (bus.instr_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("instr", 64'(bus.instr), 64'(e.ins));
            check("instr_pc", 64'(bus.instr_pc), 64'(e.pc));
        end
        tick();
        bus.instr_ready = 1'b0;
        bus.branch      = 1'b0;
        bus.zero        = 1'b0;
        check("valid_clear", 64'(bus.instr_valid), 64'd0);
    endtask

    initial begin
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        bus.instr_ready = 0; bus.branch = 0; bus.zero = 0; bus.branch_target = 0;
        bus.flush = 0; bus.flush_pc = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 64'(bus.imem_req), 64'd0);
        check("rst_addr", 64'(bus.imem_addr), 64'h0);
        check("rst_instr", 64'(bus.instr), 64'h0000_0013);
        check("rst_instr_pc", 64'(bus.instr_pc), 64'h0);
        check("rst_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_fault", 64'(bus.fetch_fault), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back sequential fetches, request every third cycle
        fetch_one(32'h0, 32'h0010_0093, 0, 0, 0, 0, 0);
        check("cyc_req0", 64'(req_cyc), 64'd1);
        fetch_one(32'h4, 32'h0020_0113, 0, 0, 0, 0, 0);
        check("cyc_req1", 64'(req_cyc), 64'd4);
        fetch_one(32'h8, 32'h0030_0193, 0, 0, 0, 0, 0);
        check("cyc_req2", 64'(req_cyc), 64'd7);
        fetch_one(32'hC, 32'h0000_0033, 0, 0, 0, 0, 0);

        // Untaken branch, grant stall, decode stall, taken branches
        fetch_one(32'h10, 32'h0000_0063, 0, 0, 1, 0, 32'h40);
        fetch_one(32'h14, 32'h0000_2003, 5, 0, 0, 0, 0);
        fetch_one(32'h18, 32'h0000_2023, 0, 4, 1, 1, 32'h10);
        fetch_one(32'h10, 32'h0000_0063, 0, 0, 1, 1, 32'h40);
        fetch_one(32'h40, 32'h0050_0293, 0, 0, 0, 0, 0);

        // Flush while waiting for the response: data must be dropped
        wait_req();
        check("wait_flush_addr", 64'(bus.imem_addr), 64'h44);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        bus.flush = 1'b1; bus.flush_pc = 32'h100;
        tick();
        bus.flush = 1'b0;
        check("drop_valid0", 64'(bus.instr_valid), 64'd0);
        check("drop_noreq", 64'(bus.imem_req), 64'd0);
        tick();
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        check("drop_valid1", 64'(bus.instr_valid), 64'd0);
        check("drop_next_req", 64'(bus.imem_req), 64'd1);
        check("drop_next_addr", 64'(bus.imem_addr), 64'h100);
        fetch_one(32'h100, 32'h0060_0313, 0, 0, 0, 0, 0);

        // Flush before grant retargets the pending request
        wait_req();
        check("pre_flush_addr", 64'(bus.imem_addr), 64'h104);
        bus.flush = 1'b1; bus.flush_pc = 32'h300;
        tick();
        bus.flush = 1'b0;
        check("fetch_flush_req", 64'(bus.imem_req), 64'd1);
        check("fetch_flush_addr", 64'(bus.imem_addr), 64'h300);

        // Branch to a misaligned target
        fetch_one(32'h300, 32'h0000_0063, 0, 0, 1, 1, 32'h42);
`ifdef IF_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            check("fault_set", 64'(bus.fetch_fault), 64'd1);
            check("fault_noreq", 64'(bus.imem_req), 64'd0);
            check("fault_novalid", 64'(bus.instr_valid), 64'd0);
            tick();
        end
        bus.flush = 1'b1; bus.flush_pc = 32'h200;
        tick();
        bus.flush = 1'b0;
        check("fault_clear", 64'(bus.fetch_fault), 64'd0);
        fetch_one(32'h200, 32'h0070_0393, 0, 0, 0, 0, 0);
`else
        check("nofault", 64'(bus.fetch_fault), 64'd0);
        fetch_one(32'h40, 32'h0070_0393, 0, 0, 0, 0, 0);
`endif

        // Flush while an instruction is presented, then PC wrap-around
        wait_req();
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0080_0413;
        tick();
        bus.imem_rvalid = 1'b0;
        check("vflush_valid", 64'(bus.instr_valid), 64'd1);
        bus.flush = 1'b1; bus.flush_pc = 32'hFFFF_FFFC;
        tick();
        bus.flush = 1'b0;
        check("vflush_drop", 64'(bus.instr_valid), 64'd0);
        fetch_one(32'hFFFF_FFFC, 32'h0090_0493, 0, 0, 0, 0, 0);
        wait_req();
        check("wrap_addr", 64'(bus.imem_addr), 64'h0);

        // Reset mid-transaction; a stray response afterwards is ignored
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 64'(bus.imem_req), 64'd0);
        check("mid_rst_addr", 64'(bus.imem_addr), 64'h0);
        check("mid_rst_valid", 64'(bus.instr_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h1111_1111;
        tick();
        bus.imem_rvalid = 1'b0;
        check("stray_rvalid", 64'(bus.instr_valid), 64'd0);
        check("stray_instr", 64'(bus.instr), 64'h0000_0013);
        fetch_one(32'h0, 32'h00A0_0513, 0, 0, 0, 0, 0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
